// File: rtl/ascii_add_sequencer.sv
// Serial front-end for the two-digit ASCII adder: parses "DD+DD=", drives the adder operands,
// captures its result and streams back "CDU\n" (or "?\n" for a malformed expression).
module ascii_add_sequencer #(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [DATA_W-1:0] op_ad,
    output logic [DATA_W-1:0] op_au,
    output logic [DATA_W-1:0] op_bd,
    output logic [DATA_W-1:0] op_bu,
    input  logic [DATA_W-1:0] res_yc,
    input  logic [DATA_W-1:0] res_yd,
    input  logic [DATA_W-1:0] res_yu,
    output logic [DATA_W-1:0] out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        op_count,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam logic [DATA_W-1:0] LF_CHAR   = DATA_W'(7'h0A);
    localparam logic [DATA_W-1:0] ERR_CHAR  = DATA_W'(7'h3F);
    localparam logic [DATA_W-1:0] ZERO_CHAR = DATA_W'(7'h30);
    localparam logic [DATA_W-1:0] NINE_CHAR = DATA_W'(7'h39);
    localparam logic [DATA_W-1:0] PLUS_CHAR = DATA_W'(7'h2B);
    localparam logic [DATA_W-1:0] EQ_CHAR   = DATA_W'(7'h3D);

    typedef enum logic [3:0] {
        GET_AD, GET_AU, GET_PLUS, GET_BD, GET_BU, GET_EQ, CALC,
        SEND_C, SEND_D, SEND_U, SEND_LF, ERR_Q, ERR_LF
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] res_c_q, res_d_q, res_u_q;
    logic              accept, out_fire, err_entry, op_done;

    function automatic logic is_digit(input logic [DATA_W-1:0] c);
        return (c >= ZERO_CHAR) && (c <= NINE_CHAR);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept    = char_valid && char_ready;
    assign out_fire  = out_valid && out_ready;
    assign err_entry = accept && (state_d == ERR_Q);
    assign op_done   = (state_q == SEND_LF) && out_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= GET_AD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_AD:   if (accept) state_d = is_digit(char_in) ? GET_AU : ERR_Q;
            GET_AU:   if (accept) state_d = is_digit(char_in) ? GET_PLUS : ERR_Q;
            GET_PLUS: if (accept) state_d = (char_in == PLUS_CHAR) ? GET_BD : ERR_Q;
            GET_BD:   if (accept) state_d = is_digit(char_in) ? GET_BU : ERR_Q;
            GET_BU:   if (accept) state_d = is_digit(char_in) ? GET_EQ : ERR_Q;
            GET_EQ:   if (accept) state_d = (char_in == EQ_CHAR) ? CALC : ERR_Q;
            CALC:     state_d = SEND_C;
            SEND_C:   if (out_fire) state_d = SEND_D;
            SEND_D:   if (out_fire) state_d = SEND_U;
            SEND_U:   if (out_fire) state_d = SEND_LF;
            SEND_LF:  if (out_fire) state_d = GET_AD;
            ERR_Q:    if (out_fire) state_d = ERR_LF;
            ERR_LF:   if (out_fire) state_d = GET_AD;
            default:  state_d = GET_AD;
        endcase
    end

    always_comb begin
        char_ready = 1'b0;
        out_valid  = 1'b0;
        out_char   = '0;
        busy       = (state_q != GET_AD);
        case (state_q)
            GET_AD, GET_AU, GET_PLUS, GET_BD, GET_BU, GET_EQ: char_ready = 1'b1;
            SEND_C:  begin out_valid = 1'b1; out_char = res_c_q;  end
            SEND_D:  begin out_valid = 1'b1; out_char = res_d_q;  end
            SEND_U:  begin out_valid = 1'b1; out_char = res_u_q;  end
            SEND_LF: begin out_valid = 1'b1; out_char = LF_CHAR;  end
            ERR_Q:   begin out_valid = 1'b1; out_char = ERR_CHAR; end
            ERR_LF:  begin out_valid = 1'b1; out_char = LF_CHAR;  end
            default: ;
        endcase
    end

    // Operands only change in the collection states, so they stay put while a result is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ad <= ZERO_CHAR;
            op_au <= ZERO_CHAR;
            op_bd <= ZERO_CHAR;
            op_bu <= ZERO_CHAR;
        end else if (accept && is_digit(char_in)) begin
            case (state_q)
                GET_AD:  op_ad <= char_in;
                GET_AU:  op_au <= char_in;
                GET_BD:  op_bd <= char_in;
                GET_BU:  op_bu <= char_in;
                default: ;
            endcase
        end
    end

    // The adder has had the whole CALC cycle to settle when its outputs are sampled here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_c_q <= ZERO_CHAR;
            res_d_q <= ZERO_CHAR;
            res_u_q <= ZERO_CHAR;
        end else if (state_q == CALC) begin
            res_c_q <= res_yc;
            res_d_q <= res_yd;
            res_u_q <= res_yu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count  <= 8'd0;
            err_count <= 8'd0;
        end else begin
            if (op_done)   op_count  <= op_count + 8'd1;
            if (err_entry) err_count <= sat_inc(err_count);
        end
    end

endmodule
